// File: rtl/cpu_timing_gen.sv
// Beat/phase sequencer for the control unit: 4-beat fetch then 4-beat execute per
// instruction, with run/step control, memory stall, halt detection and a retire counter.
module cpu_timing_gen #(
  parameter logic [7:0] HALT_OPCODE = 8'hFF,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic             stall,
  input  logic [7:0]       mem_data,
  output logic [3:0]       slow,
  output logic             quick,
  output logic [7:0]       ir,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_slow, w_slow_nxt;
  logic [7:0]       r_ir, w_ir_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_quick, r_busy, r_halted;

  always_comb begin
    // NOTE: every next-state signal gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_slow_nxt  = r_slow;
    w_ir_nxt    = r_ir;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        w_slow_nxt = 4'b0000;
        if (run && !stall) begin
          w_state_nxt = S_FETCH;
          w_slow_nxt  = 4'b1000;
        end
      end
      S_FETCH: if (!stall) begin
        if (r_slow[1]) w_ir_nxt = mem_data;
        if (r_slow[0]) begin
          w_state_nxt = S_EXEC;
          w_slow_nxt  = 4'b1000;
        end else begin
          w_slow_nxt = r_slow >> 1;
        end
      end
      S_EXEC: if (!stall) begin
        if (r_slow[0]) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          // Halt wins over single-step.
          if (r_ir == HALT_OPCODE) begin
            w_state_nxt = S_HALT;
            w_slow_nxt  = 4'b0000;
          end else if (step) begin
            w_state_nxt = S_IDLE;
            w_slow_nxt  = 4'b0000;
          end else begin
            w_state_nxt = S_FETCH;
            w_slow_nxt  = 4'b1000;
          end
        end else begin
          w_slow_nxt = r_slow >> 1;
        end
      end
      S_HALT: w_slow_nxt = 4'b0000;
      default: begin
        w_state_nxt = S_IDLE;
        w_slow_nxt  = 4'b0000;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_slow   <= 4'b0000;
      r_ir     <= 8'h00;
      r_cnt    <= '0;
      r_quick  <= 1'b0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_slow   <= w_slow_nxt;
      r_ir     <= w_ir_nxt;
      r_cnt    <= w_cnt_nxt;
      r_quick  <= (w_state_nxt == S_FETCH);
      r_busy   <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_EXEC);
      r_halted <= (w_state_nxt == S_HALT);
    end
  end

  assign slow      = r_slow;
  assign quick     = r_quick;
  assign ir        = r_ir;
  assign busy      = r_busy;
  assign halted    = r_halted;
  assign instr_cnt = r_cnt;

endmodule

// File: tb/tb_cpu_timing_gen.sv
// Randomized self-checking bench for cpu_timing_gen against an instruction-position model.
// A narrow counter keeps the wrap scenario short.
module tb_cpu_timing_gen;

  localparam int CNT_W = 4;
  localparam int VW    = 15 + CNT_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             run, step, stall;
  logic [7:0]       mem_data;
  logic [3:0]       slow;
  logic             quick, busy, halted;
  logic [7:0]       ir;
  logic [CNT_W-1:0] instr_cnt;
  logic [VW-1:0]    dut_vec;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  // Model: position 0..7 inside the current instruction (0-3 fetch, 4-7 execute).
  bit               m_active, m_halt;
  int               m_pos;
  logic [7:0]       m_ir;
  logic [CNT_W-1:0] m_cnt;

  cpu_timing_gen #(.HALT_OPCODE(8'hFF), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .stall(stall),
    .mem_data(mem_data), .slow(slow), .quick(quick), .ir(ir), .busy(busy),
    .halted(halted), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  assign dut_vec = {slow, quick, busy, halted, ir, instr_cnt};

  always @(negedge clk) if (chk_en) begin
    n_checks++;
    if (!(slow inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000}) || busy !== (slow != 4'b0000)) begin
      n_fail++;
      $display("FAIL onehot_busy t=%0t: slow=%b busy=%b", $time, slow, busy);
    end
  end

  function automatic logic [VW-1:0] exp_vec();
    logic [3:0] s;
    logic       q;
    s = m_active ? (4'b1000 >> (m_pos % 4)) : 4'b0000;
    q = m_active && (m_pos < 4);
    return {s, q, m_active, m_halt, m_ir, m_cnt};
  endfunction

  task automatic model_reset();
    m_active = 0; m_halt = 0; m_pos = 0; m_ir = 8'h00; m_cnt = '0;
  endtask

  task automatic model_edge(input logic r, input logic s, input logic st, input logic [7:0] md);
    if (m_halt) return;
    if (!m_active) begin
      if (r && !st) begin m_active = 1; m_pos = 0; end
    end else if (!st) begin
      if (m_pos == 2) m_ir = md;
      if (m_pos == 7) begin
        m_cnt = m_cnt + 1'b1;
        if (m_ir == 8'hFF) begin m_halt = 1; m_active = 0; end
        else if (s) m_active = 0;
        else m_pos = 0;
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic drive_cycle(input logic r, input logic s, input logic st, input logic [7:0] md);
    run = r; step = s; stall = st; mem_data = md;
    @(posedge clk);
    model_edge(r, s, st, md);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    run = 0; step = 0; stall = 0;
    rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    run = 0; step = 0; stall = 0; mem_data = 8'h00;
    rst_n = 1;
    #2 rst_n = 0;
    #1 model_reset();
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL reset_value: got %h expected %h", dut_vec, exp_vec());
    end
    chk_en = 1;
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(i >= 6, 1'($urandom_range(0, 1)), i >= 6, 8'($urandom));
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL reset_idle cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_run_halt();
    apply_reset();
    for (int i = 1; i <= 17; i++) begin
      drive_cycle(1, 0, 0, (m_cnt == 0) ? 8'h06 : 8'hFF);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL run_halt cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
      if (i == 8) begin
        n_checks++;
        if (ir !== 8'h06 || slow !== 4'b0001 || quick !== 1'b0) begin
          n_fail++; $display("FAIL run_halt_ir1: ir=%h slow=%b quick=%b expected 06/0001/0", ir, slow, quick);
        end
      end
    end
    n_checks++;
    if (halted !== 1'b1 || instr_cnt !== 4'd2 || slow !== 4'b0000 || ir !== 8'hFF) begin
      n_fail++;
      $display("FAIL run_halt_end: halted=%b cnt=%0d slow=%b ir=%h expected 1/2/0000/FF", halted, instr_cnt, slow, ir);
    end
  endtask

  task automatic test_single_step();
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 9; i++) begin
        drive_cycle(i == 0, 1, 0, 8'h02);
        n_checks++;
        if (dut_vec !== exp_vec()) begin
          n_fail++; $display("FAIL single_step cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
        end
      end
      n_checks++;
      if (busy !== 1'b0 || instr_cnt !== CNT_W'(k + 1) || ir !== 8'h02) begin
        n_fail++; $display("FAIL single_step_idle %0d: busy=%b cnt=%0d ir=%h expected 0/%0d/02", k, busy, instr_cnt, ir, k + 1);
      end
      for (int i = 0; i < 4; i++) begin
        drive_cycle(0, 1, 1'($urandom_range(0, 1)), 8'h02);
        n_checks++;
        if (dut_vec !== exp_vec()) begin
          n_fail++; $display("FAIL single_step_wait cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
        end
      end
    end
  endtask

  task automatic test_stall();
    int busy_cycles;
    bit found;
    apply_reset();
    busy_cycles = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      drive_cycle(1, 1, 0, 8'($urandom));
      busy_cycles += busy;
      found = m_active && m_pos == 2;
    end
    n_checks++;
    if (!found || slow !== 4'b0010 || quick !== 1'b1) begin
      n_fail++; $display("FAIL stall_reach: slow=%b quick=%b expected 0010/1", slow, quick);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, 1, 1, 8'hA0 + 8'(i));
      busy_cycles += busy;
      n_checks++;
      if (slow !== 4'b0010 || dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL stall_hold cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    drive_cycle(1, 1, 0, 8'h3C);
    busy_cycles += busy;
    n_checks++;
    if (ir !== 8'h3C || slow !== 4'b0001) begin
      n_fail++; $display("FAIL stall_capture: ir=%h slow=%b expected 3C/0001", ir, slow);
    end
    for (int i = 0; i < 12; i++) begin
      drive_cycle(0, 1, 0, 8'($urandom));
      busy_cycles += busy;
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL stall_tail cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (busy_cycles != 11 || instr_cnt !== 4'd1) begin
      n_fail++; $display("FAIL stall_length: busy cycles %0d cnt %0d expected 11/1", busy_cycles, instr_cnt);
    end
  endtask

  task automatic test_async_reset();
    bit found;
    apply_reset();
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      drive_cycle(1, 0, 0, 8'h5A);
      found = m_active && m_pos == 5;
    end
    n_checks++;
    if (!found || slow !== 4'b0100 || quick !== 1'b0 || ir !== 8'h5A) begin
      n_fail++; $display("FAIL async_reach: slow=%b quick=%b ir=%h expected 0100/0/5A", slow, quick, ir);
    end
    #2 rst_n = 0;
    #1 model_reset();
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL async_reset: got %h expected %h", dut_vec, exp_vec());
    end
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(i == 5, 0, 0, 8'h5A);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL async_after cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 1; i <= 16 * 8 + 1; i++) begin
      drive_cycle(1'($urandom_range(0, 1)) | (i == 1), 0, 0, 8'h0D);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL wrap cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (instr_cnt !== '0 || slow !== 4'b1000 || quick !== 1'b1) begin
      n_fail++; $display("FAIL wrap_end: cnt=%0d slow=%b quick=%b expected 0/1000/1", instr_cnt, slow, quick);
    end
  endtask

  task automatic test_halt_step();
    apply_reset();
    for (int i = 0; i < 9; i++) drive_cycle(1, 1, 0, 8'hFF);
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1, 1, 1'($urandom_range(0, 1)), 8'($urandom));
      n_checks++;
      if (halted !== 1'b1 || slow !== 4'b0000 || dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL halt_hold cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    apply_reset();
    n_checks++;
    if (halted !== 1'b0 || instr_cnt !== '0) begin
      n_fail++; $display("FAIL halt_exit: halted=%b cnt=%0d expected 0/0", halted, instr_cnt);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      if (m_halt && $urandom_range(0, 7) == 0) apply_reset();
      drive_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom_range(0, 3) == 0,
                  ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom));
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_halt();
    test_single_step();
    test_stall();
    test_async_reset();
    test_wrap();
    test_halt_step();
    test_random();
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_timing_gen.md
# cpu_timing_gen

Beat and phase sequencer that drives the control unit's `slow` (one-hot beat) and `quick` (fetch-phase flag) inputs, and holds the instruction register that feeds its `ir` input. Each instruction runs as a 4-beat fetch cycle (`quick`=1) followed by a 4-beat execute cycle (`quick`=0). The block sits directly upstream of the control unit. It also handles run and single-step control, memory stall, halt detection, and retired-instruction counting.

## Interface
Parameters:
- `HALT_OPCODE`, 8'hFF, opcode that stops the sequencer after its execute cycle
- `CNT_W`, 16, width of retired-instruction counter

Ports:
- `clk`  in  1  system clock, rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `run`  in  1  level; start/continue sequencing from IDLE
- `step`  in  1  level; 1 = return to IDLE after each instruction
- `stall`  in  1  memory wait; freezes beat and state
- `mem_data`  in  8  instruction byte from memory data bus
- `slow`  out  4  one-hot beat: 1000, 0100, 0010, 0001; 0000 when not sequencing
- `quick`  out  1  1 during fetch cycle, 0 otherwise
- `ir`  out  8  instruction register
- `busy`  out  1  1 in FETCH or EXEC
- `halted`  out  1  1 in HALT
- `instr_cnt`  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

## Operation
- States: IDLE, FETCH, EXEC, HALT. All outputs are registered.
- Reset (async, any state, mid-instruction included) forces the following values immediately: IDLE, `slow`=0000, `quick`=0, `ir`=8'h00, `busy`=0, `halted`=0, `instr_cnt`=0.
- IDLE:
  - `slow`=0000, `quick`=0.
  - If `run`=1 and `stall`=0, next state is FETCH with `slow`=1000.
- FETCH:
  - `quick`=1.
  - Beat advances 1000→0100→0010→0001, one per non-stalled edge.
  - `ir`<=`mem_data` on the non-stalled edge that leaves beat 0010.
  - Leaving beat 0001 goes to EXEC, `slow`=1000.
- EXEC:
  - `quick`=0; same beat rotation.
  - Leaving beat 0001, `instr_cnt` increments, then:
    - if `ir`==HALT_OPCODE, go to HALT;
    - else if `step`=1, go to IDLE;
    - else go to FETCH, `slow`=1000.
- HALT:
  - `slow`=0000, `quick`=0, `halted`=1.
  - `run` and `step` are ignored; only reset exits.
- `stall`=1 in FETCH or EXEC holds state, `slow`, `quick`, `ir` and `instr_cnt` unchanged. `stall` has no effect in IDLE or HALT, except that it blocks the IDLE→FETCH start.
- `run` deasserted mid-instruction is ignored; the instruction completes. In non-step mode, `run`=0 at the EXEC/0001 exit still continues to FETCH; `run` is sampled only in IDLE.
- `step` is sampled only at the EXEC/0001 exit edge.
- Halt priority over step: if HALT_OPCODE is executed with `step`=1, the next state is HALT.
- `ir` is never cleared except by reset; it persists through IDLE and HALT.

## Timing
- Start latency: edge sampling `run`=1 in IDLE, then `slow`=1000, `quick`=1 on the same registered update (visible the following cycle).
- Instruction length: exactly 8 non-stalled cycles, FETCH 1000 through EXEC 0001. Each stalled cycle adds 1.
- Back-to-back instructions: EXEC 0001 is followed immediately by FETCH 1000. There is no bubble.
- `ir` is valid from FETCH beat 0001 onward and stable through all of EXEC.
- `instr_cnt` and `halted` update on the same edge that leaves EXEC 0001.
- `slow` is always one-hot or 0000. Any other value is a design error; the bench asserts this every cycle.
- `busy`=1 exactly when `slow`!=0000.

## Test plan
- Reset then `run`=1, `step`=0, memory returns 8'h06 then 8'hFF:
  - expect `slow` sequence 1000,0100,0010,0001 with `quick`=1, then the same with `quick`=0, for each instruction;
  - `ir`=06 then FF;
  - HALT after 16 cycles, `halted`=1, `instr_cnt`=2, `slow`=0000.
- Single step, `step`=1, `run` pulsed 1 cycle, `mem_data`=8'h02:
  - one 8-beat instruction, then IDLE with `busy`=0, `instr_cnt`=1, `ir`=02;
  - a second pulse runs exactly one more instruction.
- Stall: assert `stall` for 3 cycles during FETCH beat 0010, with `mem_data` changing during the stall:
  - `slow` holds 0010 for 3 extra cycles;
  - `ir` captures the value present on the first non-stalled exit edge;
  - instruction takes 11 cycles.
- Async reset asserted mid-EXEC beat 0100: outputs go to reset values without waiting for a clock; after release, sequencing stays IDLE until `run`.
- Counter wrap: preload by running 65535 instructions of 8'h0D, or use a forced-counter hook. The next retirement gives `instr_cnt`=0, with no effect on sequencing.
- HALT with `step`=1 and `run` held high: sequencer stays in HALT indefinitely, `slow`=0000, until `rst_n`=0.
